ifmap_stream_feeder: RTL and testbench

//  Transmit side of the PE IFMap input FIFO. Reads a row-major ROWS x COLS feature map from

---
 rtl/ifmap_stream_feeder.sv | 188 ++++++++++++++++++
 tb/tb_ifmap_stream_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_stream_feeder.sv
// Transmit side of the PE IFMap FIFO: walks a row-major feature map in synchronous-read SRAM
// and pushes {eom, eor, data} words into the PE FIFO through a 2-entry skid buffer.
module ifmap_stream_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DIM_WIDTH-1:0]  num_rows,
    input  logic [DIM_WIDTH-1:0]  num_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_wen,
    output logic [DATA_WIDTH+1:0] fifo_din,
    input  logic                  fifo_full
);
    localparam int WORD_W = DATA_WIDTH + 2;
    localparam int CNT_W  = 2 * DIM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DIM_WIDTH-1:0]  rows_q;
    logic [DIM_WIDTH-1:0]  cols_q;
    logic [DIM_WIDTH-1:0]  row_q;
    logic [DIM_WIDTH-1:0]  col_q;
    logic [CNT_W-1:0]      total_q;
    logic [CNT_W-1:0]      issued_q;
    logic                  rd_pend_q;
    logic [1:0]            pend_tag_q;
    logic [WORD_W-1:0]     skid_q [2];
    logic                  head_q;
    logic [1:0]            count_q;

    logic                  streaming_s;
    logic                  skid_empty_s;
    logic                  pop_s;
    logic                  issue_left_s;
    logic                  ren_s;
    logic                  last_col_s;
    logic                  last_row_s;
    logic                  tail_s;
    logic [2:0]            credit_s;
    logic [WORD_W-1:0]     head_word_s;
    logic [1:0]            count_d;
    logic                  head_d;

    // Read-issue credit, skid buffer bookkeeping and the FIFO push decision.
    always_comb begin
        streaming_s  = (state_q == S_STREAM);
        skid_empty_s = (count_q == 2'd0);
        head_word_s  = skid_q[head_q];
        pop_s        = streaming_s && !skid_empty_s && !fifo_full;
        issue_left_s = (issued_q != total_q);
        // A read in flight already owns a skid slot, so it counts against the 2 entries.
        credit_s     = {1'b0, count_q} + {2'b00, rd_pend_q};
        ren_s        = streaming_s && issue_left_s && ((credit_s - {2'b00, pop_s}) < 3'd2);
        last_col_s   = (col_q == (cols_q - DIM_WIDTH'(1'b1)));
        last_row_s   = (row_q == (rows_q - DIM_WIDTH'(1'b1)));
        tail_s       = head_q ^ count_q[0];
        count_d      = count_q + {1'b0, rd_pend_q} - {1'b0, pop_s};
        head_d       = head_q ^ pop_s;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_ren  = ren_s;
    assign mem_addr = addr_q;
    assign fifo_wen = pop_s;
    assign fifo_din = head_word_s;

    // Control FSM: configuration capture, completion on the eom push, one-cycle done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rows_q  <= {DIM_WIDTH{1'b0}};
            cols_q  <= {DIM_WIDTH{1'b0}};
            total_q <= {CNT_W{1'b0}};
        end else if (clear) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rows_q  <= num_rows;
                        cols_q  <= num_cols;
                        total_q <= CNT_W'(num_rows) * CNT_W'(num_cols);
                        if ((num_rows == {DIM_WIDTH{1'b0}}) || (num_cols == {DIM_WIDTH{1'b0}})) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_STREAM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (pop_s && head_word_s[WORD_W-1]) begin
                        state_q <= S_FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read address and row/column tagging of each issued read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= {ADDR_WIDTH{1'b0}};
            issued_q <= {CNT_W{1'b0}};
            row_q    <= {DIM_WIDTH{1'b0}};
            col_q    <= {DIM_WIDTH{1'b0}};
        end else if (clear) begin
            issued_q <= {CNT_W{1'b0}};
            row_q    <= {DIM_WIDTH{1'b0}};
            col_q    <= {DIM_WIDTH{1'b0}};
        end else if ((state_q == S_IDLE) && start) begin
            addr_q   <= base_addr;
            issued_q <= {CNT_W{1'b0}};
            row_q    <= {DIM_WIDTH{1'b0}};
            col_q    <= {DIM_WIDTH{1'b0}};
        end else if (ren_s) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1'b1);
            issued_q <= issued_q + CNT_W'(1'b1);
            if (last_col_s) begin
                col_q <= {DIM_WIDTH{1'b0}};
                row_q <= row_q + DIM_WIDTH'(1'b1);
            end else begin
                col_q <= col_q + DIM_WIDTH'(1'b1);
            end
        end
    end

    // Skid buffer: returned SRAM data joins its tags at the tail, the PE FIFO drains the head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend_q  <= 1'b0;
            pend_tag_q <= 2'b00;
            skid_q[0]  <= {WORD_W{1'b0}};
            skid_q[1]  <= {WORD_W{1'b0}};
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else if (clear) begin
            rd_pend_q  <= 1'b0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            rd_pend_q <= ren_s;
            if (ren_s) begin
                pend_tag_q <= {last_col_s && last_row_s, last_col_s};
            end
            if (rd_pend_q) begin
                skid_q[tail_s] <= {pend_tag_q, mem_rdata};
            end
            head_q  <= head_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_ifmap_stream_feeder.sv
// Scoreboard bench for ifmap_stream_feeder: expected words and read addresses are queued when
// a transfer is launched and a negedge monitor pops them as the DUT reads and pushes.
module tb_ifmap_stream_feeder;
    logic        clk = 1'b0;
    logic        rstn;
    logic        clear;
    logic        start;
    logic [11:0] base_addr;
    logic [7:0]  num_rows;
    logic [7:0]  num_cols;
    logic        busy;
    logic        done;
    logic        mem_ren;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        fifo_wen;
    logic [17:0] fifo_din;
    logic        fifo_full;

    int          checks   = 0;
    int          failures = 0;
    logic [17:0] exp_q [$];
    logic [11:0] addr_q [$];
    bit          seen_push = 1'b0;

    always #5 clk = ~clk;

    ifmap_stream_feeder dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .num_cols  (num_cols),
        .busy      (busy),
        .done      (done),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .fifo_wen  (fifo_wen),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full)
    );

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {4'hC, a};
    endfunction

    // SRAM model: data is valid the cycle after the read enable
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h", nm, act);
    endtask

    task automatic load_expected(input logic [11:0] base, input logic [7:0] r, input logic [7:0] c);
        int n;
        logic [11:0] a;
        n = int'(r) * int'(c);
        for (int i = 0; i < n; i++) begin
            a = base + 12'(i);
            exp_q.push_back({(i == n - 1), ((i % int'(c)) == int'(c) - 1), mem_word(a)});
            addr_q.push_back(a);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (fifo_full) begin
                chk("no_push_when_full", fifo_wen, 1'b0);
                if (busy && seen_push && exp_q.size() > 0)
                    chk("din_held_while_full", fifo_din, exp_q[0]);
            end
            if (fifo_wen) begin
                seen_push = 1'b1;
                if (exp_q.size() == 0) fail_now("unexpected_push", fifo_din);
                else begin
                    chk("push_word", fifo_din, exp_q[0]);
                    exp_q.delete(0);
                end
            end
            if (mem_ren) begin
                if (addr_q.size() == 0) fail_now("unexpected_read", mem_addr);
                else begin
                    chk("read_addr", mem_addr, addr_q[0]);
                    addr_q.delete(0);
                end
            end
        end
    end

    task automatic launch(input logic [11:0] base, input logic [7:0] r, input logic [7:0] c, input bit full0);
        seen_push = 1'b0;
        @(posedge clk); #1;
        base_addr = base; num_rows = r; num_cols = c; start = 1'b1; fifo_full = full0;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'h5A5; num_rows = 8'd7; num_cols = 8'd9;
    endtask

    task automatic run_map(input logic [11:0] base, input logic [7:0] r, input logic [7:0] c,
                           input bit toggle, input bit start_mid);
        int n, k, first, last, dk;
        n = int'(r) * int'(c);
        load_expected(base, r, c);
        launch(base, r, c, toggle);
        first = -1; last = -1; dk = -1; k = 0;
        while (dk < 0 && k < 300) begin
            @(negedge clk);
            if (k == 0) begin
                chk("busy_after_start", busy, n != 0);
                chk("ren_after_start", mem_ren, n != 0);
            end
            if (fifo_wen) begin
                if (first < 0) first = k;
                last = k;
            end
            if (done) begin
                dk = k;
                chk("busy_low_with_done", busy, 1'b0);
            end
            @(posedge clk); #1;
            if (toggle) fifo_full = ~fifo_full;
            if (start_mid) start = (k == 2);
            k++;
        end
        start = 1'b0;
        fifo_full = 1'b0;
        if (dk < 0) fail_now("done_timeout", k);
        else if (n == 0) begin
            chk("zero_done_cycle", dk, 0);
            chk("zero_no_push", first, -1);
        end else begin
            chk("done_after_last_push", dk, last + 1);
            if (!toggle) begin
                chk("first_push_latency", first, 2);
                chk("push_span", last - first + 1, n);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("all_words_pushed", exp_q.size(), 0);
        chk("all_reads_issued", addr_q.size(), 0);
    endtask

    task automatic wait_pushes(input int target, input string nm);
        int n, k;
        n = 0; k = 0;
        while (n < target && k < 60) begin
            @(negedge clk);
            if (fifo_wen) n++;
            k++;
        end
        if (n < target) fail_now(nm, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw, nd, nr;
        rstn = 1'b0; clear = 1'b0; start = 1'b0; fifo_full = 1'b0;
        base_addr = 12'h000; num_rows = 8'd0; num_cols = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ren", mem_ren, 1'b0);
        chk("rst_wen", fifo_wen, 1'b0);
        chk("rst_addr", mem_addr, 12'h000);
        chk("rst_din", fifo_din, 18'h00000);
        rstn = 1'b1;

        run_map(12'h010, 8'd2, 8'd3, 1'b0, 1'b0);
        run_map(12'h010, 8'd2, 8'd3, 1'b1, 1'b0);
        run_map(12'h020, 8'd0, 8'd3, 1'b0, 1'b0);
        run_map(12'h020, 8'd3, 8'd0, 1'b0, 1'b0);
        run_map(12'hFFE, 8'd1, 8'd4, 1'b0, 1'b0);

        // abort a 4x4 transfer after two pushes
        load_expected(12'h100, 8'd4, 8'd4);
        launch(12'h100, 8'd4, 8'd4, 1'b0);
        wait_pushes(2, "clear_test_timeout");
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        nw = 0; nd = 0; nr = 0;
        repeat (12) begin
            @(negedge clk);
            nw = nw + int'(fifo_wen);
            nd = nd + int'(done);
            nr = nr + int'(mem_ren);
        end
        chk("clear_no_push", nw, 0);
        chk("clear_no_done", nd, 0);
        chk("clear_no_read", nr, 0);
        chk("clear_idle", busy, 1'b0);
        exp_q.delete();
        addr_q.delete();
        run_map(12'h100, 8'd4, 8'd4, 1'b0, 1'b0);

        run_map(12'h010, 8'd2, 8'd3, 1'b0, 1'b1);

        // asynchronous reset in the middle of a stream
        load_expected(12'h200, 8'd4, 8'd4);
        launch(12'h200, 8'd4, 8'd4, 1'b0);
        wait_pushes(3, "reset_test_timeout");
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_ren", mem_ren, 1'b0);
        chk("async_rst_wen", fifo_wen, 1'b0);
        chk("async_rst_addr", mem_addr, 12'h000);
        chk("async_rst_din", fifo_din, 18'h00000);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        run_map(12'h010, 8'd2, 8'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
